// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: word width, access-size encodings and FSM states.
// Imported by lsu_align and load_store_unit.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_FMT  = 2'd2,
    LSU_WR   = 2'd3
  } lsu_state_e;

  // Encoding 2'b11 is an alias for a word access.
  function automatic logic [1:0] lsu_eff_size(input logic [1:0] size);
    return (size == 2'b11) ? LSU_SZ_W : size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for a big-endian word: load extraction with sign/zero extension
// and sub-word store merge into a previously read word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [1:0]          offset_i,
  input  logic [LSU_XLEN-1:0] rword_i,
  input  logic [LSU_XLEN-1:0] wdata_i,
  output logic [LSU_XLEN-1:0] ld_data_o,
  output logic [LSU_XLEN-1:0] st_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte.
  always_comb begin
    byte_lane = rword_i[31:24];
    unique case (offset_i)
      2'd0: byte_lane = rword_i[31:24];
      2'd1: byte_lane = rword_i[23:16];
      2'd2: byte_lane = rword_i[15:8];
      2'd3: byte_lane = rword_i[7:0];
      default: byte_lane = rword_i[31:24];
    endcase
    half_lane = offset_i[1] ? rword_i[15:0] : rword_i[31:16];
  end

  always_comb begin
    ld_data_o = rword_i;
    unique case (size_i)
      LSU_SZ_B: ld_data_o = unsigned_i ? {24'h000000, byte_lane}
                                       : {{24{byte_lane[7]}}, byte_lane};
      LSU_SZ_H: ld_data_o = unsigned_i ? {16'h0000, half_lane}
                                       : {{16{half_lane[15]}}, half_lane};
      default:  ld_data_o = rword_i;
    endcase
  end

  always_comb begin
    st_word_o = rword_i;
    unique case (size_i)
      LSU_SZ_B: begin
        unique case (offset_i)
          2'd0: st_word_o[31:24] = wdata_i[7:0];
          2'd1: st_word_o[23:16] = wdata_i[7:0];
          2'd2: st_word_o[15:8]  = wdata_i[7:0];
          2'd3: st_word_o[7:0]   = wdata_i[7:0];
          default: st_word_o = rword_i;
        endcase
      end
      LSU_SZ_H: begin
        if (offset_i[1]) st_word_o[15:0]  = wdata_i[15:0];
        else             st_word_o[31:16] = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request FSM, registered memory interface and response. Sub-word stores
// are read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned requests as errors.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [LSU_XLEN-1:0] req_addr,
  input  logic [LSU_XLEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [LSU_XLEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [LSU_XLEN-1:0] mem_addr,
  output logic                mem_we,
  output logic [LSU_XLEN-1:0] mem_wdata,
  input  logic [LSU_XLEN-1:0] mem_rdata
);

  lsu_state_e          state_q;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic [LSU_XLEN-1:0] wdata_q;
  logic                resp_valid_q;
  logic [LSU_XLEN-1:0] rdata_q;
  logic [LSU_XLEN-1:0] mem_addr_q;
  logic                mem_we_q;
  logic [LSU_XLEN-1:0] mem_wdata_q;

  logic [1:0]          size_d;
  logic [1:0]          off_d;
  logic                trap_hit;
  logic [LSU_XLEN-1:0] ld_data;
  logic [LSU_XLEN-1:0] st_word;

  // Low address bits that cannot belong to the access size are dropped here.
  always_comb begin
    size_d = lsu_eff_size(req_size);
    off_d  = 2'b00;
    unique case (size_d)
      LSU_SZ_B: off_d = req_addr[1:0];
      LSU_SZ_H: off_d = {req_addr[1], 1'b0};
      default:  off_d = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  assign misalign = ((size_d == LSU_SZ_H) && req_addr[0]) ||
                    ((size_d == LSU_SZ_W) && (req_addr[1:0] != 2'b00));
  assign trap_hit = misalign;
  assign resp_err = err_q;
`else
  assign trap_hit = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .offset_i   (off_q),
    .rword_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= LSU_SZ_B;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q        <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= size_d;
            off_q   <= off_d;
            wdata_q <= req_wdata;
            if (trap_hit) begin
              // Misaligned access answers immediately without touching memory.
              resp_valid_q <= 1'b1;
              rdata_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
              err_q        <= 1'b1;
`endif
            end else begin
              mem_addr_q <= {req_addr[LSU_XLEN-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
              err_q      <= 1'b0;
`endif
              if (req_we && (size_d == LSU_SZ_W)) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
                state_q     <= LSU_WR;
              end else begin
                state_q <= LSU_RD;
              end
            end
          end
        end
        LSU_RD: begin
          state_q <= LSU_FMT;
        end
        LSU_FMT: begin
          // mem_rdata carries the addressed word in this state.
          if (we_q) begin
            mem_wdata_q <= st_word;
            mem_we_q    <= 1'b1;
            state_q     <= LSU_WR;
          end else begin
            resp_valid_q <= 1'b1;
            rdata_q      <= ld_data;
            state_q      <= LSU_IDLE;
          end
        end
        LSU_WR: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          rdata_q      <= '0;
          state_q      <= LSU_IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= LSU_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
